spi_slave_ctrl: RTL

- Synthesizable SPI slave endpoint directly downstream of the SPI master; consumes the master's spi_clk, spi_mosi and one spi_ss line, and drives spi_miso.
- Oversamples all SPI pins in the system clock domain.
- Deserializes MOSI words into a parallel output strobe and serializes parallel TX words from a one-deep hold register onto MISO.
- Supports all four CPOL/CPHA modes, selected per frame.

---
 rtl/spi_slave_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_ctrl.sv
// SPI slave endpoint: oversampled pins, MSB-first, CPOL/CPHA latched per frame, one-deep TX hold register.
// Optional feature: define SPI_SLAVE_WORD_CNT_EN to add the saturating rx_word_cnt output.
module spi_slave_ctrl #(
   parameter int data_width_c  = 8,
   parameter int sync_stages_c = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    spi_clk,
   input  logic                    spi_mosi,
   input  logic                    spi_ss,
   output logic                    spi_miso,
   output logic                    spi_miso_oe,
   input  logic                    cpol,
   input  logic                    cpha,
   input  logic [data_width_c-1:0] tx_din,
   input  logic                    tx_din_valid,
   output logic                    tx_req,
   output logic                    tx_underrun,
   output logic [data_width_c-1:0] rx_dout,
   output logic                    rx_dout_valid,
`ifdef SPI_SLAVE_WORD_CNT_EN
   output logic [15:0]             rx_word_cnt,
`endif
   output logic                    busy
);

   localparam int cnt_w_c = $clog2(data_width_c);
   localparam logic [cnt_w_c-1:0] last_cnt_c = cnt_w_c'(data_width_c - 1);

   typedef enum logic {IDLE, XFER} state_t;

   state_t state_reg, state_next;

   logic [sync_stages_c-1:0] sclk_sync_reg, mosi_sync_reg, ss_sync_reg;
   logic                     sclk_prev_reg, ss_prev_reg;
   logic                     cpol_reg, cpha_reg;
   logic [cnt_w_c-1:0]       bit_cnt_reg;
   logic [data_width_c-2:0]  rx_shift_reg;
   logic [data_width_c-1:0]  tx_shift_reg, hold_reg;
   logic                     hold_valid_reg;

   logic sclk_s, mosi_s, ss_s;
   logic sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic lead_edge, trail_edge, active;
   logic frame_start, frame_end, sample_evt, shift_evt, load_evt, word_done;
   logic [data_width_c-1:0] rx_word_next;

   // Pins reach logic only through the synchronizers; ss resets high so reset release never looks like a frame start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_reg <= '0;
         mosi_sync_reg <= '0;
         ss_sync_reg   <= '1;
         sclk_prev_reg <= 1'b0;
         ss_prev_reg   <= 1'b1;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[sync_stages_c-2:0], spi_clk};
         mosi_sync_reg <= {mosi_sync_reg[sync_stages_c-2:0], spi_mosi};
         ss_sync_reg   <= {ss_sync_reg[sync_stages_c-2:0], spi_ss};
         sclk_prev_reg <= sclk_sync_reg[sync_stages_c-1];
         ss_prev_reg   <= ss_sync_reg[sync_stages_c-1];
      end
   end

   assign sclk_s    = sclk_sync_reg[sync_stages_c-1];
   assign mosi_s    = mosi_sync_reg[sync_stages_c-1];
   assign ss_s      = ss_sync_reg[sync_stages_c-1];
   assign sclk_rise = sclk_s & ~sclk_prev_reg;
   assign sclk_fall = ~sclk_s & sclk_prev_reg;
   assign ss_rise   = ss_s & ~ss_prev_reg;
   assign ss_fall   = ~ss_s & ss_prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      active      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ss_fall) begin
               state_next  = XFER;
               frame_start = 1'b1;
            end
         end
         XFER: begin
            if (ss_rise) begin
               state_next = IDLE;
               frame_end  = 1'b1;
            end else begin
               active = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A frame end in the same cycle as an edge suppresses the edge (active is low).
   assign lead_edge  = cpol_reg ? sclk_fall : sclk_rise;
   assign trail_edge = cpol_reg ? sclk_rise : sclk_fall;
   assign sample_evt = active & (cpha_reg ? trail_edge : lead_edge);
   assign shift_evt  = active & (cpha_reg ? lead_edge : trail_edge);
   assign word_done  = sample_evt & (bit_cnt_reg == last_cnt_c);
   // With the counter at zero a shift edge is always the first one of a word (cpha=1) or follows a completed word (cpha=0).
   assign load_evt   = (frame_start & ~cpha) | (shift_evt & (bit_cnt_reg == '0));
   assign rx_word_next = {rx_shift_reg, mosi_s};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpol_reg       <= 1'b0;
         cpha_reg       <= 1'b0;
         busy           <= 1'b0;
         spi_miso_oe    <= 1'b0;
         bit_cnt_reg    <= '0;
         rx_shift_reg   <= '0;
         rx_dout        <= '0;
         rx_dout_valid  <= 1'b0;
         tx_shift_reg   <= '0;
         tx_underrun    <= 1'b0;
         hold_reg       <= '0;
         hold_valid_reg <= 1'b0;
      end else begin
         rx_dout_valid <= 1'b0;
         tx_underrun   <= 1'b0;

         if (tx_din_valid && (!hold_valid_reg || load_evt)) begin
            hold_reg       <= tx_din;
            hold_valid_reg <= 1'b1;
         end else if (load_evt) begin
            hold_valid_reg <= 1'b0;
         end

         if (frame_start) begin
            cpol_reg    <= cpol;
            cpha_reg    <= cpha;
            busy        <= 1'b1;
            spi_miso_oe <= 1'b1;
            bit_cnt_reg <= '0;
         end else if (frame_end) begin
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            bit_cnt_reg <= '0;
         end else if (sample_evt) begin
            rx_shift_reg <= rx_word_next[data_width_c-2:0];
            if (word_done) begin
               rx_dout       <= rx_word_next;
               rx_dout_valid <= 1'b1;
               bit_cnt_reg   <= '0;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
         end

         if (frame_end) begin
            tx_shift_reg <= '0;
         end else if (load_evt) begin
            tx_shift_reg <= hold_valid_reg ? hold_reg : '0;
            tx_underrun  <= ~hold_valid_reg;
         end else if (shift_evt) begin
            tx_shift_reg <= {tx_shift_reg[data_width_c-2:0], 1'b0};
         end
      end
   end

   assign spi_miso = tx_shift_reg[data_width_c-1];
   assign tx_req   = ~hold_valid_reg;

`ifdef SPI_SLAVE_WORD_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               rx_word_cnt <= '0;
      else if (frame_start)                   rx_word_cnt <= '0;
      else if (word_done && rx_word_cnt != 16'hFFFF) rx_word_cnt <= rx_word_cnt + 16'd1;
   end
`endif

endmodule
